// File: rtl/button_evt_gen.sv
// Button front end: 2-flop synchronizer, stability-counter debounce, single-cycle press event.
// Define BUTTON_EVT_GEN_AUTOREPEAT_EN to compile in the hold-to-repeat timer and REPEAT state.
module button_evt_gen #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic btn_in,
   input  logic enable_in,
   output logic evt_out,
   output logic pressed_out,
   output logic repeat_active_out
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   logic            sync1_q;
   logic            sync2_q;
   logic [DB_W-1:0] db_cnt_q;
   logic [DB_W-1:0] db_cnt_d;
   logic            pressed_q;
   logic            pressed_d;
   state_t          state_q;
   state_t          state_d;
   logic            evt_q;
   logic            evt_d;
   logic            rep_act_q;
   logic            rep_act_d;
   logic            rise_s;
   logic            fall_s;
   logic            rpt_fire_s;

   // Synchronizer: the only reader of the raw button
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: count consecutive samples disagreeing with the accepted level
   always_comb begin
      db_cnt_d  = '0;
      pressed_d = pressed_q;
      if (sync2_q == pressed_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         pressed_d = ~pressed_q;
         db_cnt_d  = '0;
      end else begin
         db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   assign rise_s = pressed_d & ~pressed_q;
   assign fall_s = pressed_q & ~pressed_d;

`ifdef BUTTON_EVT_GEN_AUTOREPEAT_EN
   localparam int RT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RT_W   = $clog2(RT_MAX + 1);

   logic [RT_W-1:0] rpt_cnt_q;
   logic [RT_W-1:0] rpt_cnt_d;

   // Repeat timer register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rpt_cnt_q <= '0;
      end else begin
         rpt_cnt_q <= rpt_cnt_d;
      end
   end

   // FSM next state and repeat scheduling; a release on the firing edge cancels the pulse
   always_comb begin
      state_d    = state_q;
      rpt_cnt_d  = rpt_cnt_q;
      rpt_fire_s = 1'b0;
      case (state_q)
         IDLE: begin
            rpt_cnt_d = '0;
            if (rise_s) begin
               state_d = HELD;
            end else begin
               state_d = IDLE;
            end
         end
         HELD: begin
            if (fall_s) begin
               state_d   = IDLE;
               rpt_cnt_d = '0;
            end else if (rpt_cnt_q == RT_W'(REPEAT_DELAY - 1)) begin
               state_d    = REPEAT;
               rpt_cnt_d  = '0;
               rpt_fire_s = 1'b1;
            end else begin
               rpt_cnt_d = rpt_cnt_q + RT_W'(1);
            end
         end
         REPEAT: begin
            if (fall_s) begin
               state_d   = IDLE;
               rpt_cnt_d = '0;
            end else if (rpt_cnt_q == RT_W'(REPEAT_PERIOD - 1)) begin
               rpt_cnt_d  = '0;
               rpt_fire_s = 1'b1;
            end else begin
               rpt_cnt_d = rpt_cnt_q + RT_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
         end
      endcase
   end
`else
   logic unused_rpt_s;
   assign unused_rpt_s = ^{REPEAT_DELAY, REPEAT_PERIOD};

   // FSM next state without auto-repeat: REPEAT is unreachable
   always_comb begin
      state_d    = state_q;
      rpt_fire_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise_s) begin
               state_d = HELD;
            end else begin
               state_d = IDLE;
            end
         end
         HELD: begin
            if (fall_s) begin
               state_d = IDLE;
            end else begin
               state_d = HELD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end
`endif

   // Output decode: enable only gates the pulse, suppressed events are dropped
   always_comb begin
      evt_d     = enable_in & (rise_s | rpt_fire_s);
      rep_act_d = (state_d == REPEAT);
   end

   // Main state and output registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         db_cnt_q  <= '0;
         pressed_q <= 1'b0;
         state_q   <= IDLE;
         evt_q     <= 1'b0;
         rep_act_q <= 1'b0;
      end else begin
         db_cnt_q  <= db_cnt_d;
         pressed_q <= pressed_d;
         state_q   <= state_d;
         evt_q     <= evt_d;
         rep_act_q <= rep_act_d;
      end
   end

   assign evt_out           = evt_q;
   assign pressed_out       = pressed_q;
   assign repeat_active_out = rep_act_q;

endmodule
